fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front end. It holds the fetch PC and issues word reads to instruction memory over a request/grant/response interface, one request in flight at a time. Each returned word goes to the execute stage through a valid/ready output register. The PC redirects computed by the branch unit are applied here: a redirect discards any stale in-flight or buffered instruction and restarts fetch at the new target.

## Interface

Parameters:
- RESET_PC, default 32'h0000_0000: fetch address used after reset; bits [1:0] must be zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- pc_in  in  32 (register_t)  redirect target from the branch unit.
- pc_load  in  1  single-cycle pulse; fetch restarts at pc_in.
- mem_req  out  1  read request valid.
- mem_addr  out  32  word-aligned read address, meaningful while mem_req=1.
- mem_gnt  in  1  memory accepts the request; honoured only while mem_req=1.
- mem_rvalid  in  1  read data valid; honoured only in WAIT.
- mem_rdata  in  32  read data.
- instr_valid  out  1  instr and instr_pc are valid.
- instr  out  32 (instruction_t)  fetched instruction.
- instr_pc  out  32  address the instruction was fetched from.
- instr_ready  in  1  execute stage consumes instr this cycle.

## Operation

- Registers:
  - fetch PC fpc.
  - address of the in-flight request, ipc.
  - drop flag.
  - output register, made up of instr, instr_pc and instr_valid.
  - state, one of IDLE, REQ, WAIT, HOLD.
- Reset values: state=IDLE, fpc=RESET_PC, ipc=0, drop=0, instr_valid=0, instr=0, instr_pc=0.
- mem_req = (state==REQ). mem_addr = fpc, so it is RESET_PC during reset.
- IDLE:
  - Goes to REQ unconditionally on the next edge.
  - pc_load in IDLE sets fpc<=pc_in.
- REQ:
  - On mem_gnt: ipc<=fpc, fpc<=fpc+4, go to WAIT.
  - Without mem_gnt: stay in REQ with mem_req held.
- WAIT:
  - On mem_rvalid with drop=0: instr<=mem_rdata, instr_pc<=ipc, instr_valid<=1, go to HOLD.
  - On mem_rvalid with drop=1: discard the data, drop<=0, go to REQ.
- HOLD: on instr_ready, instr_valid<=0 and go to REQ.
- Redirect (pc_load=1). In every state fpc<=pc_in with bits [1:0] forced to 0. Additionally, per state:
  - REQ without mem_gnt: stay in REQ. mem_addr changes to the new target on the next cycle; memory must tolerate a request address changing before grant.
  - REQ with mem_gnt in the same cycle: the request counts as issued; drop<=1, go to WAIT. fpc still becomes pc_in, not fpc+4.
  - WAIT without mem_rvalid: drop<=1.
  - WAIT with mem_rvalid in the same cycle: discard the data and go to REQ.
  - HOLD: instr_valid<=0 and go to REQ, whether or not instr_ready is asserted. If instr_ready is asserted, the consumer has taken the instruction.
- Arithmetic: fpc+4 is a 32-bit add and wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored; they cause no state change.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). Any in-flight response arriving after reset release is ignored, because the unit is in IDLE or REQ.

## Timing

- Grant at edge N, response at edge N+k (k≥1): instr_valid=1 from cycle N+k+1.
- Earliest mem_req is the second cycle after reset deassertion (one IDLE cycle first).
- Minimum spacing between accepted instructions is 3 cycles (REQ, WAIT, HOLD) when grant and response are immediate and instr_ready=1.
- pc_load at edge M: mem_req with mem_addr=pc_in no later than cycle M+1 if no request is in flight. If a request is in flight, mem_req rises the cycle after its response arrives.
- instr_valid falls the cycle after pc_load. No instruction from the old stream is ever presented after a pc_load edge.
- While instr_valid=1 and instr_ready=0, instr and instr_pc are stable.

## Test plan

- Reset with RESET_PC=32'h100, memory grants and responds immediately, instr_ready=1 -> mem_addr sequence 0x100, 0x104, 0x108; instr_pc matches each address; instr equals mem_rdata.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1 with instr stable, mem_req=0; one cycle after instr_ready=1, mem_req=1 at the next address.
- Redirect during WAIT: grant at 0x200, pc_load with pc_in=0x400, response 0xDEADBEEF 3 cycles later -> 0xDEADBEEF never presented; next mem_addr=0x400, then instr_pc=0x400.
- pc_load and mem_gnt in the same cycle, pc_in=0x80 -> response for the old address discarded; next request at 0x80, the one after at 0x84.
- Wrap: pc_in=32'hFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000. Also pc_in=0x103 -> mem_addr=0x100.
- Asynchronous reset asserted mid-WAIT -> instr_valid=0 and mem_req=0 immediately; a late mem_rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Single outstanding word read,
//            valid/ready instruction output register, branch redirects.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_load,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] ipc_q, ipc_d;
    logic        drop_q, drop_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] target;

    assign target = pc_in & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fpc_q      <= RESET_PC;
            ipc_q      <= 32'h0;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            ipc_q      <= ipc_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        ipc_d      = ipc_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (mem_gnt) begin
                    ipc_d   = fpc_q;
                    fpc_d   = fpc_q + 32'd4;
                    state_d = S_WAIT;
                    // Granted in the redirect cycle: the response belongs to the old stream.
                    if (pc_load) drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (drop_q || pc_load) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d    = mem_rdata;
                        instr_pc_d = ipc_q;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else if (pc_load) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (pc_load || instr_ready) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect always wins over the sequential fpc+4 update.
        if (pc_load) fpc_d = target;
    end

    assign mem_req     = (state_q == S_REQ);
    assign mem_addr    = fpc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule
`default_nettype wire
